pipe_skid_buffer: RTL and testbench

Two-entry valid/ready pipeline register stage (skid buffer) that decouples an upstream producer from a downstream consumer in the sequential datapath. It gives full throughput (one transfer per cycle) with both `s_ready` and `m_valid` driven straight from flops, so no combinational path crosses the stage. It sits directly upstream of the team's enable-gated data registers: `m_valid & m_ready` is the load enable for the consuming register bank.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_skid_buffer.sv | 92 +++++++++
 tb/tb_pipe_skid_buffer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-buffer stage: state encoding and
// occupancy width.
package pipe_pkg;

    localparam int unsigned COUNT_W = 2;

    typedef enum logic [COUNT_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer. s_ready, m_valid and m_data are all
// driven from flops, so no combinational path crosses the stage.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic [COUNT_W-1:0] count
);

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] skid;
    logic             accept;
    logic             pop;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign accept = s_valid & s_ready;
    assign pop    = m_valid & m_ready;
    assign count  = state;

    always_comb begin
        nxt            = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    nxt       = ST_BUSY;
                    load_main = 1'b1;
                end
            end
            ST_BUSY: begin
                if (accept && !pop) begin
                    nxt       = ST_FULL;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    nxt            = ST_BUSY;
                    main_from_skid = 1'b1;
                end
            end
            default: nxt = ST_EMPTY;
        endcase
        // Flush voids any handshake in this cycle; data registers keep stale values.
        if (flush) begin
            nxt            = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            skid    <= '0;
        end else begin
            state   <= nxt;
            s_ready <= (nxt != ST_FULL);
            m_valid <= (nxt != ST_EMPTY);
            if (load_main)
                m_data <= s_data;
            else if (main_from_skid)
                m_data <= skid;
            if (load_skid)
                skid <= s_data;
        end
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed bench for pipe_skid_buffer: a queue scoreboard holds words in
// flight and the front is compared with m_data whenever m_valid is expected.
module tb_pipe_skid_buffer;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic             exp_ready = 1'b0;
    logic             exp_valid = 1'b0;
    logic             exp_zero  = 1'b1;

    pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the scoreboard from the driven inputs and the
    // expected handshake state, then compare outputs at the following negedge.
    task automatic tick(input string tag);
        logic acc;
        logic pp;
        acc = s_valid & exp_ready;
        pp  = exp_valid & m_ready;
        if (rst) begin
            q.delete();
            exp_ready = 1'b0;
            exp_valid = 1'b0;
            exp_zero  = 1'b1;
        end else if (flush) begin
            q.delete();
            exp_ready = 1'b1;
            exp_valid = 1'b0;
        end else begin
            if (pp)
                void'(q.pop_front());
            if (acc) begin
                q.push_back(s_data);
                exp_zero = 1'b0;
            end
            exp_ready = (q.size() != 2);
            exp_valid = (q.size() != 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(exp_ready));
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(exp_valid));
        chk({tag, ".count"},   32'(count),   32'(q.size()));
        if (exp_valid)
            chk({tag, ".m_data"}, 32'(m_data), 32'(q[0]));
        else if (exp_zero)
            chk({tag, ".m_data_rst"}, 32'(m_data), 32'd0);
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        s_valid = v;
        s_data  = d;
        m_ready = r;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b1, 4'hA, 1'b0);
        @(negedge clk);

        // Reset held for three cycles with input activity
        tick("rst0");
        tick("rst1");
        tick("rst2");
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0);
        tick("rst_rel");

        // Streaming at full throughput, then simultaneous accept/pop in BUSY
        drive(1'b1, 4'h1, 1'b1); tick("stream1");
        drive(1'b1, 4'h2, 1'b1); tick("stream2");
        drive(1'b1, 4'h3, 1'b1); tick("stream3");
        chk("stream3.word", 32'(m_data), 32'h3);
        drive(1'b1, 4'h4, 1'b1); tick("accpop");
        chk("accpop.word", 32'(m_data), 32'h4);
        drive(1'b0, 4'h0, 1'b1); tick("drain0");

        // Backpressure: fill both entries, offer a third word that must be ignored
        drive(1'b1, 4'hA, 1'b0); tick("bp_a");
        drive(1'b1, 4'h5, 1'b0); tick("bp_5");
        chk("bp_full.count", 32'(count), 32'd2);
        drive(1'b1, 4'h7, 1'b0); tick("bp_hold");
        chk("bp_hold.word", 32'(m_data), 32'hA);
        drive(1'b0, 4'h0, 1'b1); tick("bp_pop1");
        chk("bp_pop1.ready", 32'(s_ready), 32'd1);
        tick("bp_pop2");

        // Flush in FULL with a concurrent pop and accept, then a fresh word
        drive(1'b1, 4'h1, 1'b0); tick("fl_fill1");
        drive(1'b1, 4'h2, 1'b0); tick("fl_fill2");
        flush = 1'b1;
        drive(1'b1, 4'h9, 1'b1); tick("flush");
        flush = 1'b0;
        drive(1'b1, 4'hF, 1'b1); tick("fl_push");
        chk("fl_push.word", 32'(m_data), 32'hF);
        drive(1'b0, 4'h0, 1'b1); tick("fl_drain");

        // Reset in FULL with live handshakes
        drive(1'b1, 4'h3, 1'b0); tick("mr_fill1");
        drive(1'b1, 4'h6, 1'b0); tick("mr_fill2");
        rst = 1'b1;
        drive(1'b1, 4'hC, 1'b1); tick("mid_rst");
        chk("mid_rst.word", 32'(m_data), 32'h0);
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b1); tick("mr_rel");
        drive(1'b1, 4'h8, 1'b1); tick("mr_push");
        drive(1'b0, 4'h0, 1'b1); tick("mr_drain");
        tick("mr_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
